// File: rtl/cic_comb_decimator_if.sv
// rtl/cic_comb_decimator_if.sv - sample-in / result-out bundle for the CIC comb decimator
//
// Purpose: groups the integrator-sample input and the decimated-result output
// of cic_comb_decimator so that one handle connects the source and the sink.
// Signals:
//   in_valid  - input_0 carries a new integrator sample this cycle
//   input_0   - signed integrator running sum
//   out_valid - one-cycle strobe, output_0 carries a new comb result
//   output_0  - signed comb result
//   primed    - delay line holds DIFF_DELAY kept samples
// Modports: master drives samples and observes results; slave is the decimator.
interface cic_comb_decimator_if #(
  parameter int WIDTH = 10
);
  logic                    in_valid;
  logic signed [WIDTH-1:0] input_0;
  logic                    out_valid;
  logic signed [WIDTH-1:0] output_0;
  logic                    primed;

  modport master (
    output in_valid, input_0,
    input  out_valid, output_0, primed
  );

  modport slave (
    input  in_valid, input_0,
    output out_valid, output_0, primed
  );
endinterface

// File: rtl/cic_comb_decimator.sv
// rtl/cic_comb_decimator.sv - decimating comb stage of a single-stage CIC decimator
//
// Purpose: keeps every RATE-th valid integrator sample and emits the modular
// difference between it and the kept sample DIFF_DELAY decimation steps back.
// Ports:
//   system1000     - clock, rising edge
//   system1000_rst - synchronous active-high reset, overrides everything
//   bus (slave)    - in_valid/input_0 in; out_valid/output_0/primed out
module cic_comb_decimator #(
  parameter int WIDTH      = 10,
  parameter int RATE       = 4,
  parameter int DIFF_DELAY = 1
) (
  input  logic               system1000,
  input  logic               system1000_rst,
  cic_comb_decimator_if.slave bus
);

  localparam int            PW   = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [PW-1:0] LAST = PW'(RATE - 1);
  localparam logic [1:0]    FULL = 2'(DIFF_DELAY);

  typedef enum logic {PRIME, RUN} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [1:0]              cnt_q, cnt_d;
  logic signed [WIDTH-1:0] delay_q [DIFF_DELAY];
  logic signed [WIDTH-1:0] delay_d [DIFF_DELAY];
  logic signed [WIDTH-1:0] out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    primed_q, primed_d;
  logic                    keep;
  logic signed [WIDTH-1:0] diff;

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q  <= PRIME;
      phase_q  <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
      for (int i = 0; i < DIFF_DELAY; i++) delay_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      primed_q <= primed_d;
      for (int i = 0; i < DIFF_DELAY; i++) delay_q[i] <= delay_d[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    primed_d = primed_q;
    delay_d  = delay_q;
    keep     = bus.in_valid && (phase_q == LAST);
    // Truncating subtraction gives the mod 2^WIDTH difference the comb needs.
    diff     = bus.input_0 - delay_q[DIFF_DELAY-1];

    if (bus.in_valid) begin
      phase_d = keep ? '0 : phase_q + 1'b1;
    end

    if (keep) begin
      delay_d[0] = bus.input_0;
      for (int i = 1; i < DIFF_DELAY; i++) delay_d[i] = delay_q[i-1];

      case (state_q)
        PRIME: begin
          // The sample completing the prime count only fills the delay line.
          cnt_d = cnt_q + 2'd1;
          if (cnt_q + 2'd1 == FULL) begin
            state_d  = RUN;
            primed_d = 1'b1;
          end
        end
        RUN: begin
          out_d   = diff;
          valid_d = 1'b1;
        end
        default: state_d = PRIME;
      endcase
    end
  end

  assign bus.output_0  = out_q;
  assign bus.out_valid = valid_q;
  assign bus.primed    = primed_q;

endmodule

// File: tb/tb_cic_comb_decimator.sv
// tb/tb_cic_comb_decimator.sv - directed self-checking bench for cic_comb_decimator
module tb_cic_comb_decimator;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cic_comb_decimator_if #(.WIDTH(10)) ba ();
  cic_comb_decimator_if #(.WIDTH(10)) bb ();

  cic_comb_decimator #(.WIDTH(10), .RATE(4), .DIFF_DELAY(1)) dut_a (
    .system1000     (clk),
    .system1000_rst (rst),
    .bus            (ba.slave)
  );

  cic_comb_decimator #(.WIDTH(10), .RATE(2), .DIFF_DELAY(2)) dut_b (
    .system1000     (clk),
    .system1000_rst (rst),
    .bus            (bb.slave)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_a(input logic v, input int x);
    ba.in_valid = v;
    ba.input_0  = 10'(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_b(input logic v, input int x);
    bb.in_valid = v;
    bb.input_0  = 10'(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst         = 1'b1;
    ba.in_valid = 1'b0;
    bb.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    int  last;
    int  prev;
    int  j;
    logic v;
    logic ev;

    rst         = 1'b1;
    ba.in_valid = 1'b0;
    ba.input_0  = '0;
    bb.in_valid = 1'b0;
    bb.input_0  = '0;

    // Reset then idle: everything stays at zero.
    do_reset(3);
    for (int i = 0; i < 5; i++) begin
      step_a(1'b0, 0);
      check("idle_valid",  ba.out_valid, 0);
      check("idle_out",    ba.output_0,  0);
      check("idle_primed", ba.primed,    0);
    end

    // Steady ramp 3,6,9,...: kept 12 primes, then 24,36,48 each give 12.
    last = 0;
    for (int i = 1; i <= 16; i++) begin
      step_a(1'b1, 3 * i);
      ev = (i % 4 == 0) && (i > 4);
      if (ev) last = 12;
      check("ramp_valid",  ba.out_valid, ev);
      check("ramp_out",    ba.output_0,  last);
      check("ramp_primed", ba.primed,    i >= 4);
    end

    // Wrap-around: 508 then 520 (seen as -504) must give 12.
    do_reset(1);
    for (int i = 1; i <= 8; i++) begin
      step_a(1'b1, (i == 4) ? 508 : (i == 8) ? -504 : 0);
      check("wrap_valid", ba.out_valid, i == 8);
    end
    check("wrap_out", ba.output_0, 12);

    // Sparse valid: alternate cycles; results 8 cycles apart, value 12.
    do_reset(1);
    j    = 0;
    prev = 0;
    for (int k = 1; k <= 32; k++) begin
      v = (k % 2 == 1);
      if (v) j++;
      step_a(v, v ? 3 * j : -1);
      ev = v && (j % 4 == 0) && (j > 4);
      check("sparse_valid", ba.out_valid, ev);
      if (ev) begin
        check("sparse_out", ba.output_0, 12);
        if (prev != 0) check("sparse_spacing", k - prev, 8);
        prev = k;
      end
    end

    // Reset mid-stream on a would-be kept sample; reset must win.
    do_reset(1);
    for (int i = 1; i <= 7; i++) step_a(1'b1, 10 * i);
    rst         = 1'b1;
    ba.in_valid = 1'b1;
    ba.input_0  = 10'd80;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid",  ba.out_valid, 0);
    check("midrst_out",    ba.output_0,  0);
    check("midrst_primed", ba.primed,    0);
    for (int i = 1; i <= 8; i++) begin
      step_a(1'b1, 10 * i);
      check("reprime_valid",  ba.out_valid, i == 8);
      check("reprime_primed", ba.primed,    i >= 4);
    end
    check("reprime_out", ba.output_0, 40);
    ba.in_valid = 1'b0;

    // RATE=2, M=2: kept 2,4 prime; 6,8,10,12 each give 4.
    do_reset(1);
    last = 0;
    for (int i = 1; i <= 12; i++) begin
      step_b(1'b1, i);
      ev = (i % 2 == 0) && (i > 4);
      if (ev) last = 4;
      check("m2_valid",  bb.out_valid, ev);
      check("m2_out",    bb.output_0,  last);
      check("m2_primed", bb.primed,    i >= 4);
    end
    step_b(1'b0, 0);
    check("m2_hold_valid", bb.out_valid, 0);
    check("m2_hold_out",   bb.output_0,  4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
